seg_pattern_decoder: RTL and testbench
======================================

// Module: seg_pattern_decoder
// PURPOSE
// - Receive side of the seven-segment output path: takes 8-bit segment patterns (a..g plus dp),
//   as driven on uo_out by the segment drivers, and recovers 4-bit hex digits.
// - Decoded digits are buffered in a small FIFO behind a valid/ready handshake.
// - Unrecognised patterns are flagged and counted.
// - Used as a loopback checker and on-chip capture of display traffic.
// PARAMETERS
// - FIFO_DEPTH     4  entries in the digit FIFO; power of two, 2..16
// - STABLE_CYCLES  3  consecutive identical samples required before capture (filter mode only); 1..15
// PORTS
// - clk         in   1  single clock; all logic rising-edge
// - rst         in   1  synchronous reset, active-high
// - seg_in      in   8  pattern: bit0=a .. bit6=g, bit7=dp; active-high segments
// - seg_valid   in   1  seg_in is meaningful this cycle
// - seg_ready   out  1  decoder can accept a pattern this cycle
// - dig_out     out  4  decoded hex digit at FIFO head
// - dig_dp      out  1  dp bit carried with the FIFO head
// - dig_err     out  1  FIFO head came from an unrecognised pattern
// - dig_valid   out  1  FIFO head is valid
// - dig_ready   in   1  consumer pops the head when dig_valid && dig_ready
// - fill_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH
// - err_count   out  8  saturating count of unrecognised patterns accepted
// BEHAVIOUR
// - Reset: FIFO empty; dig_valid=0, dig_out=0, dig_dp=0, dig_err=0, fill_level=0, err_count=0;
//   seg_ready=1 from the first cycle after reset. Reset mid-transfer discards all buffered entries.
// - Decode table on seg_in[6:0]:
//   3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F.
// - Any other code stores digit 0 with err=1; dp is stored unchanged from seg_in[7] in all cases.
// - Accept when seg_valid && seg_ready. Decode is combinational; entry is written at that edge.
// - dig_valid rises the cycle after the first accept into an empty FIFO (latency 1; no bypass).
// - seg_ready = !full, taken from registered occupancy.
// - When full, a same-cycle pop does not reopen ready; ready returns the cycle after the pop.
// - Simultaneous push and pop when neither full nor empty: both occur, fill_level unchanged.
// - Pointers wrap modulo FIFO_DEPTH.
// - dig_out/dig_dp/dig_err hold their value while dig_valid && !dig_ready.
// - err_count increments on each accepted error entry and saturates at 255; it does not wrap.
// CONFIGURATION
// - Macro SEG_STABLE_FILTER_EN.
// - Undefined: every accepted handshake pushes exactly one entry.
// - Defined: glitch filter for sampling raw pins. seg_in is sampled every cycle seg_valid=1; seg_ready stays = !full.
//   - FSM IDLE -> TRACK on seg_valid, storing the sample and setting run=1.
//   - TRACK: same sample -> run++; different sample -> restart run=1 with the new value;
//     seg_valid=0 -> IDLE.
//   - When run reaches STABLE_CYCLES -> CAPTURE. CAPTURE pushes one entry if !full (else drops it),
//     then -> HOLD.
//   - HOLD: no further pushes while the sample is unchanged. A change -> TRACK with run=1;
//     seg_valid=0 -> IDLE.
//   - A drop on a full FIFO does not increment err_count.
// TESTING
// - Reset, then push 3F,06,5B,4F with dig_ready=1 -> dig_out 0,1,2,3 one cycle after each accept; dig_err=0.
// - Push 8 patterns with dig_ready=0 (depth 4) -> seg_ready low after 4 accepts, fill_level=4;
//   one pop -> ready high next cycle.
// - Push 0x80|7F then 0x00 -> head dig_out=8, dig_dp=1; next entry dig_out=0, dig_err=1; err_count=1.
// - Push 300 invalid codes while draining -> err_count saturates at 255.
// - Fill to 2, push and pop in the same cycle -> fill_level stays 2; output order is preserved.
// - Assert rst with 3 entries buffered -> next cycle dig_valid=0, fill_level=0, err_count=0.
// - SEG_STABLE_FILTER_EN: apply 6D for 2 cycles, 7D for 5 cycles -> exactly one entry (6); no entry for 5.

Source files
------------

// File: rtl/seg_pattern_decoder_if.sv
// Handshake bundle for seg_pattern_decoder: segment input side and decoded digit FIFO side.
// The decoder uses the slave modport; the pattern source and the digit consumer use master.
interface seg_pattern_decoder_if;
  logic [7:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic [3:0] dig_out;
  logic       dig_dp;
  logic       dig_err;
  logic       dig_valid;
  logic       dig_ready;
  logic [4:0] fill_level;
  logic [7:0] err_count;

  modport master (
    output seg_in, seg_valid, dig_ready,
    input  seg_ready, dig_out, dig_dp, dig_err, dig_valid, fill_level, err_count
  );

  modport slave (
    input  seg_in, seg_valid, dig_ready,
    output seg_ready, dig_out, dig_dp, dig_err, dig_valid, fill_level, err_count
  );
endinterface

// File: rtl/seg_pattern_decoder.sv
// Seven-segment pattern decoder feeding a small digit FIFO, with saturating error counter.
// Optional glitch filter on raw pin samples is enabled by defining SEG_STABLE_FILTER_EN.
//
// Filter FSM (SEG_STABLE_FILTER_EN only):
//   state     | meaning
//   S_IDLE    | seg_valid low, nothing tracked
//   S_TRACK   | counting consecutive identical samples in run_q
//   S_CAPTURE | sample stable long enough; push one entry (dropped if FIFO full)
//   S_HOLD    | entry taken for this sample; wait for a change or seg_valid low
module seg_pattern_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst,
  seg_pattern_decoder_if.slave bus
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..15");
  end

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  typedef struct packed {
    logic       err;
    logic       dp;
    logic [3:0] dig;
  } entry_t;

  function automatic entry_t decode(input logic [7:0] seg);
    entry_t e;
    e.dp  = seg[7];
    e.err = 1'b0;
    case (seg[6:0])
      7'h3F: e.dig = 4'h0;
      7'h06: e.dig = 4'h1;
      7'h5B: e.dig = 4'h2;
      7'h4F: e.dig = 4'h3;
      7'h66: e.dig = 4'h4;
      7'h6D: e.dig = 4'h5;
      7'h7D: e.dig = 4'h6;
      7'h07: e.dig = 4'h7;
      7'h7F: e.dig = 4'h8;
      7'h6F: e.dig = 4'h9;
      7'h77: e.dig = 4'hA;
      7'h7C: e.dig = 4'hB;
      7'h39: e.dig = 4'hC;
      7'h5E: e.dig = 4'hD;
      7'h79: e.dig = 4'hE;
      7'h71: e.dig = 4'hF;
      default: begin
        e.dig = 4'h0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q;
  logic [7:0]    err_cnt_q;

  logic   full;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  assign full = (count_q == DEPTH_L);
  assign pop  = (count_q != 5'd0) && bus.dig_ready;

`ifdef SEG_STABLE_FILTER_EN
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_CAPTURE, S_HOLD} state_t;

  localparam logic [3:0] STABLE_L = 4'(STABLE_CYCLES);

  state_t     state_q;
  logic [7:0] samp_q;
  logic [3:0] run_q;

  // A fresh sample starts a run of 1, which is already stable when STABLE_CYCLES is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      samp_q  <= 8'h00;
      run_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.seg_valid) begin
            samp_q  <= bus.seg_in;
            run_q   <= 4'd1;
            state_q <= (STABLE_L == 4'd1) ? S_CAPTURE : S_TRACK;
          end
        end
        S_TRACK: begin
          if (!bus.seg_valid) begin
            state_q <= S_IDLE;
          end else if (bus.seg_in == samp_q) begin
            run_q <= run_q + 4'd1;
            if (run_q + 4'd1 == STABLE_L) state_q <= S_CAPTURE;
          end else begin
            samp_q  <= bus.seg_in;
            run_q   <= 4'd1;
            state_q <= (STABLE_L == 4'd1) ? S_CAPTURE : S_TRACK;
          end
        end
        S_CAPTURE: state_q <= S_HOLD;
        S_HOLD: begin
          if (!bus.seg_valid) begin
            state_q <= S_IDLE;
          end else if (bus.seg_in != samp_q) begin
            samp_q  <= bus.seg_in;
            run_q   <= 4'd1;
            state_q <= (STABLE_L == 4'd1) ? S_CAPTURE : S_TRACK;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign push       = (state_q == S_CAPTURE) && !full;
  assign push_entry = decode(samp_q);
`else
  assign push       = bus.seg_valid && !full;
  assign push_entry = decode(bus.seg_in);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      err_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
      if (push && push_entry.err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.seg_ready  = !full;
  assign bus.dig_out    = head.dig;
  assign bus.dig_dp     = head.dp;
  assign bus.dig_err    = head.err;
  assign bus.dig_valid  = (count_q != 5'd0);
  assign bus.fill_level = count_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Self-checking bench for seg_pattern_decoder: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_seg_pattern_decoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_pattern_decoder_if u_if ();

  seg_pattern_decoder #(
    .FIFO_DEPTH   (DEPTH),
    .STABLE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] dig;
    logic       dp;
    logic       err;
  } ent_t;

  ent_t     mq[$];
  int       m_err = 0;
  bit [6:0] codes[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic ent_t ref_decode(input logic [7:0] s);
    ent_t e;
    e.dp  = s[7];
    e.dig = 4'h0;
    e.err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (codes[i] == s[6:0]) begin
        e.dig = 4'(i);
        e.err = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef SEG_STABLE_FILTER_EN
  // One clock with the current inputs; model advances on the same edge, then outputs are compared.
  task automatic step();
    bit   acc, pp;
    ent_t e;
    acc = u_if.seg_valid && (mq.size() < DEPTH);
    pp  = (mq.size() > 0) && u_if.dig_ready;
    e   = ref_decode(u_if.seg_in);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_err = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (e.err && m_err < 255) m_err++;
      end
    end
    #1;
    check("seg_ready", u_if.seg_ready, 32'(mq.size() < DEPTH));
    check("dig_valid", u_if.dig_valid, 32'(mq.size() > 0));
    check("fill_level", u_if.fill_level, 32'(mq.size()));
    check("err_count", u_if.err_count, 32'(m_err));
    if (mq.size() > 0) begin
      check("dig_out", u_if.dig_out, 32'(mq[0].dig));
      check("dig_dp", u_if.dig_dp, 32'(mq[0].dp));
      check("dig_err", u_if.dig_err, 32'(mq[0].err));
    end
  endtask

  task automatic push_seg(input logic [7:0] s, input logic rdy);
    u_if.seg_valid = 1'b1;
    u_if.seg_in    = s;
    u_if.dig_ready = rdy;
    step();
  endtask

  task automatic idle(input logic rdy);
    u_if.seg_valid = 1'b0;
    u_if.dig_ready = rdy;
    step();
  endtask
`endif

  initial begin
    rst            = 1'b1;
    u_if.seg_in    = 8'h00;
    u_if.seg_valid = 1'b0;
    u_if.dig_ready = 1'b0;
`ifndef SEG_STABLE_FILTER_EN
    step();
    rst = 1'b0;
    check("reset_dig_out", u_if.dig_out, 32'h0);
    check("reset_dig_dp", u_if.dig_dp, 32'h0);
    check("reset_dig_err", u_if.dig_err, 32'h0);
    idle(1'b0);

    // In-order decode of the first four digits.
    push_seg(8'h3F, 1'b1);
    push_seg(8'h06, 1'b1);
    push_seg(8'h5B, 1'b1);
    push_seg(8'h4F, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: eight offers into a depth-4 FIFO with no consumer.
    for (int i = 0; i < 8; i++) push_seg({1'b0, codes[i + 4]}, 1'b0);
    check("full_fill", u_if.fill_level, 32'd4);
    check("full_ready", u_if.seg_ready, 32'd0);
    idle(1'b1);
    check("ready_after_pop", u_if.seg_ready, 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // dp carried through, invalid pattern flagged.
    push_seg(8'hFF, 1'b0);
    push_seg(8'h00, 1'b0);
    check("dp_head_dig", u_if.dig_out, 32'h8);
    check("dp_head_dp", u_if.dig_dp, 32'h1);
    idle(1'b1);
    check("err_head_err", u_if.dig_err, 32'h1);
    check("err_count_one", u_if.err_count, 32'd1);
    idle(1'b1);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) push_seg({1'($urandom_range(0, 1)), 7'h00}, 1'b1);
    idle(1'b1);
    check("err_sat", u_if.err_count, 32'd255);
    idle(1'b1);

    // Simultaneous push and pop at occupancy 2.
    push_seg(8'h66, 1'b0);
    push_seg(8'h6D, 1'b0);
    push_seg(8'h7D, 1'b1);
    check("pushpop_fill", u_if.fill_level, 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset with three buffered entries.
    push_seg(8'h07, 1'b0);
    push_seg(8'h00, 1'b0);
    push_seg(8'h39, 1'b0);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    check("rst_mid_valid", u_if.dig_valid, 32'd0);
    check("rst_mid_err", u_if.err_count, 32'd0);

    // Random traffic, mixing table codes and arbitrary bytes.
    for (int i = 0; i < 600; i++) begin
      u_if.seg_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        u_if.seg_in = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
      else
        u_if.seg_in = 8'($urandom);
      u_if.dig_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
`else
    tick();
    rst = 1'b0;
    check("reset_valid", u_if.dig_valid, 32'd0);
    check("reset_fill", u_if.fill_level, 32'd0);
    check("reset_ready", u_if.seg_ready, 32'd1);
    check("reset_err", u_if.err_count, 32'd0);

    // 6D briefly, then 7D held long: only the stable 7D yields one entry.
    u_if.seg_valid = 1'b1;
    u_if.seg_in    = 8'h6D;
    tick();
    tick();
    u_if.seg_in = 8'h7D;
    for (int i = 0; i < 5; i++) tick();
    u_if.seg_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("flt_fill", u_if.fill_level, 32'd1);
    check("flt_dig", u_if.dig_out, 32'h6);
    check("flt_err", u_if.dig_err, 32'd0);
    check("flt_dp", u_if.dig_dp, 32'd0);
    u_if.dig_ready = 1'b1;
    tick();
    u_if.dig_ready = 1'b0;
    check("flt_pop", u_if.fill_level, 32'd0);

    // Held pattern captured once; a one-cycle blip afterwards is rejected.
    u_if.seg_valid = 1'b1;
    u_if.seg_in    = 8'hBF;
    for (int i = 0; i < 6; i++) tick();
    u_if.seg_in = 8'h5B;
    tick();
    u_if.seg_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flt2_fill", u_if.fill_level, 32'd1);
    check("flt2_dig", u_if.dig_out, 32'h0);
    check("flt2_dp", u_if.dig_dp, 32'd1);
    check("flt2_errcnt", u_if.err_count, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
